// File: rtl/add_subb_serial_if.sv
// Operand/result handshake bundle for add_subb_serial.
// Carries z only when ADD_SUBB_SERIAL_ZERO_EN is defined.
interface add_subb_serial_if #(
    parameter int unsigned W = 4,
    parameter int unsigned N = 2
);
    logic           in_valid;
    logic           in_ready;
    logic           subb_a;
    logic           subb_b;
    logic [N*W-1:0] a;
    logic [N*W-1:0] b;
    logic           out_valid;
    logic           out_ready;
    logic [N*W-1:0] s;
    logic           ovf;
`ifdef ADD_SUBB_SERIAL_ZERO_EN
    logic           z;
`endif

    modport master (
        output in_valid, subb_a, subb_b, a, b, out_ready,
        input  in_ready, out_valid, s, ovf
`ifdef ADD_SUBB_SERIAL_ZERO_EN
        , input z
`endif
    );

    modport slave (
        input  in_valid, subb_a, subb_b, a, b, out_ready,
        output in_ready, out_valid, s, ovf
`ifdef ADD_SUBB_SERIAL_ZERO_EN
        , output z
`endif
    );
endinterface

// File: rtl/add_subb_serial.sv
// Limb-serial signed add/subtract: s = (+/-a) + (+/-b), one W-bit limb per enabled clock.
// Optional zero flag z is built when ADD_SUBB_SERIAL_ZERO_EN is defined.
module add_subb_serial #(
    parameter int unsigned W = 4,
    parameter int unsigned N = 2
) (
    input logic             clk,
    input logic             rst,
    input logic             ena,
    add_subb_serial_if.slave bus
);
    localparam int unsigned CW = $clog2(N);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e                state_q;
    logic [CW-1:0]         cnt_q;
    logic [1:0]            carry_q;
    logic [N-1:0][W-1:0]   a_q;
    logic [N-1:0][W-1:0]   b_q;
    logic [N-1:0][W-1:0]   s_q;
    logic                  subb_a_q;
    logic                  subb_b_q;
    logic                  ovf_q;

    logic [W-1:0]          limb_a;
    logic [W-1:0]          limb_b;
    logic [W+1:0]          limb_sum;
    logic [W+1:0]          top_sum;
    logic                  last_limb;
    logic                  top_ovf;

    // Negation is invert here plus the +1 preloaded into the carry at accept.
    always_comb begin
        limb_a    = a_q[cnt_q] ^ {W{subb_a_q}};
        limb_b    = b_q[cnt_q] ^ {W{subb_b_q}};
        limb_sum  = {2'b00, limb_a} + {2'b00, limb_b} + {{W{1'b0}}, carry_q};
        top_sum   = {{2{limb_a[W-1]}}, limb_a} + {{2{limb_b[W-1]}}, limb_b}
                    + {{W{1'b0}}, carry_q};
        top_ovf   = (top_sum != {{2{top_sum[W-1]}}, top_sum[W-1:0]});
        last_limb = (cnt_q == CW'(N - 1));
    end

`ifdef ADD_SUBB_SERIAL_ZERO_EN
    logic nz_q;
    logic z_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            carry_q  <= '0;
            a_q      <= '0;
            b_q      <= '0;
            s_q      <= '0;
            subb_a_q <= 1'b0;
            subb_b_q <= 1'b0;
            ovf_q    <= 1'b0;
`ifdef ADD_SUBB_SERIAL_ZERO_EN
            nz_q     <= 1'b0;
            z_q      <= 1'b0;
`endif
        end else if (ena) begin
            case (state_q)
                StIdle: begin
                    if (bus.in_valid) begin
                        a_q      <= bus.a;
                        b_q      <= bus.b;
                        subb_a_q <= bus.subb_a;
                        subb_b_q <= bus.subb_b;
                        carry_q  <= {1'b0, bus.subb_a} + {1'b0, bus.subb_b};
                        cnt_q    <= '0;
`ifdef ADD_SUBB_SERIAL_ZERO_EN
                        nz_q     <= 1'b0;
`endif
                        state_q  <= StRun;
                    end
                end
                StRun: begin
                    s_q[cnt_q] <= limb_sum[W-1:0];
                    carry_q    <= limb_sum[W+1:W];
`ifdef ADD_SUBB_SERIAL_ZERO_EN
                    nz_q       <= nz_q | (|limb_sum[W-1:0]);
`endif
                    if (last_limb) begin
                        ovf_q   <= top_ovf;
`ifdef ADD_SUBB_SERIAL_ZERO_EN
                        z_q     <= ~(nz_q | (|limb_sum[W-1:0]));
`endif
                        cnt_q   <= '0;
                        state_q <= StDone;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                StDone: begin
                    if (bus.out_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.s         = s_q;
    assign bus.ovf       = ovf_q;
`ifdef ADD_SUBB_SERIAL_ZERO_EN
    assign bus.z         = z_q;
`endif
endmodule

// File: tb/tb_add_subb_serial.sv
// Randomised self-checking bench for add_subb_serial (W=4, N=2) against an integer model.
module tb_add_subb_serial;
    localparam int unsigned W  = 4;
    localparam int unsigned N  = 2;
    localparam int unsigned WN = N * W;

    logic clk = 1'b0;
    logic rst;
    logic ena;

    always #5 clk = ~clk;

    add_subb_serial_if #(.W(W), .N(N)) bus ();

    add_subb_serial #(.W(W), .N(N)) dut (
        .clk (clk),
        .rst (rst),
        .ena (ena),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Exact signed arithmetic, then wrap to WN bits.
    function automatic void model(input logic [WN-1:0] a_v, input logic [WN-1:0] b_v,
                                  input logic sa, input logic sb,
                                  output logic [WN-1:0] s_v, output logic ovf_v);
        int ea;
        int eb;
        int sum;
        ea = int'($signed(a_v));
        eb = int'($signed(b_v));
        if (sa) ea = -ea;
        if (sb) eb = -eb;
        sum   = ea + eb;
        s_v   = sum[WN-1:0];
        ovf_v = (sum > (2 ** (WN - 1)) - 1) || (sum < -(2 ** (WN - 1)));
    endfunction

    task automatic run_op(input logic [WN-1:0] a_v, input logic [WN-1:0] b_v,
                          input logic sa, input logic sb,
                          input int ena_pct, input int rdy_pct, input int stall);
        logic [WN-1:0] exp_s;
        logic          exp_ovf;
        logic          en;
        logic          rdy;
        logic          done;
        int            n_en;
        int            guard;
        model(a_v, b_v, sa, sb, exp_s, exp_ovf);

        check_eq("in_ready_idle", bus.in_ready, 1);
        bus.a        = a_v;
        bus.b        = b_v;
        bus.subb_a   = sa;
        bus.subb_b   = sb;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b0;
        ena          = 1'b1;
        step();
        check_eq("in_ready_run", bus.in_ready, 0);

        n_en  = 0;
        guard = 0;
        while (!bus.out_valid && guard < 200) begin
            // Operands are scrambled while busy; they must be ignored.
            bus.a        = WN'($urandom);
            bus.b        = WN'($urandom);
            bus.subb_a   = 1'($urandom);
            bus.subb_b   = 1'($urandom);
            bus.in_valid = 1'($urandom);
            en  = ($urandom_range(99) < ena_pct);
            ena = en;
            step();
            guard++;
            if (en) n_en++;
            check_eq("latency", bus.out_valid, (n_en >= int'(N)));
        end
        check_eq("valid_timeout", bus.out_valid, 1);
        check_eq("s", bus.s, exp_s);
        check_eq("ovf", bus.ovf, exp_ovf);
`ifdef ADD_SUBB_SERIAL_ZERO_EN
        check_eq("z", bus.z, (exp_s == '0));
`endif
        check_eq("in_ready_done", bus.in_ready, 0);

        for (int i = 0; i < stall; i++) begin
            bus.out_ready = 1'b0;
            ena = 1'b1;
            step();
            check_eq("stall_valid", bus.out_valid, 1);
            check_eq("stall_s", bus.s, exp_s);
            check_eq("stall_ovf", bus.ovf, exp_ovf);
            check_eq("stall_in_ready", bus.in_ready, 0);
        end

        done  = 1'b0;
        guard = 0;
        while (!done && guard < 200) begin
            rdy = ($urandom_range(99) < rdy_pct);
            en  = ($urandom_range(99) < ena_pct);
            bus.out_ready = rdy;
            bus.in_valid  = 1'($urandom);
            ena = en;
            step();
            guard++;
            if (en && rdy) begin
                done = 1'b1;
            end else begin
                check_eq("hold_valid", bus.out_valid, 1);
                check_eq("hold_s", bus.s, exp_s);
            end
        end
        check_eq("exit_timeout", done, 1);
        check_eq("exit_valid", bus.out_valid, 0);
        check_eq("exit_in_ready", bus.in_ready, 1);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        ena           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.subb_a    = 1'b0;
        bus.subb_b    = 1'b0;
        step();
        step();
        check_eq("rst_in_ready", bus.in_ready, 1);
        check_eq("rst_out_valid", bus.out_valid, 0);
        check_eq("rst_s", bus.s, 0);
        check_eq("rst_ovf", bus.ovf, 0);

        // No acceptance while ena is low.
        rst = 1'b0;
        bus.in_valid = 1'b1;
        step();
        step();
        check_eq("ena0_in_ready", bus.in_ready, 1);
        check_eq("ena0_out_valid", bus.out_valid, 0);
        bus.in_valid = 1'b0;

        // Directed corner cases.
        run_op(8'h7F, 8'h01, 1'b0, 1'b0, 100, 100, 0);
        run_op(8'h10, 8'h01, 1'b0, 1'b1, 100, 100, 0);
        run_op(8'h01, 8'h01, 1'b1, 1'b1, 100, 100, 0);
        run_op(8'h05, 8'h05, 1'b0, 1'b1, 100, 100, 0);
        run_op(8'h80, 8'h00, 1'b1, 1'b0, 100, 100, 0);
        run_op(8'h80, 8'h80, 1'b0, 1'b0, 100, 100, 0);
        run_op(8'h7F, 8'h01, 1'b0, 1'b0, 100, 100, 5);

        // Three ena-low cycles mid-run delay the result by exactly three.
        bus.a = 8'h12; bus.b = 8'h34; bus.subb_a = 1'b0; bus.subb_b = 1'b0;
        bus.in_valid = 1'b1;
        ena = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        ena = 1'b0;
        bus.a = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("gap_valid", bus.out_valid, 0);
        end
        ena = 1'b1;
        step();
        check_eq("gap_valid_end", bus.out_valid, 1);
        check_eq("gap_s", bus.s, 8'h46);
        check_eq("gap_ovf", bus.ovf, 0);
        bus.out_ready = 1'b1;
        step();
        check_eq("gap_exit", bus.in_ready, 1);
        bus.out_ready = 1'b0;

        // Reset during RUN discards the operation.
        bus.a = 8'h13; bus.b = 8'h01;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("rrun_in_ready", bus.in_ready, 1);
        check_eq("rrun_out_valid", bus.out_valid, 0);
        check_eq("rrun_s", bus.s, 0);
        check_eq("rrun_ovf", bus.ovf, 0);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("rrun_no_valid", bus.out_valid, 0);
        end
        bus.out_ready = 1'b0;

        // Random operands, handshakes and clock enables.
        for (int i = 0; i < 1000; i++) begin
            run_op(WN'($urandom), WN'($urandom), 1'($urandom), 1'($urandom), 100, 100, 0);
        end
        for (int i = 0; i < 2000; i++) begin
            run_op(WN'($urandom), WN'($urandom), 1'($urandom), 1'($urandom), 70, 60, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
